// File: rtl/decrypted_block_store_pkg.sv
// decrypted_block_store_pkg: shared state encoding for the decrypted block store
package decrypted_block_store_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } store_state_e;
endpackage

// File: rtl/decrypted_block_store_ram.sv
// block_store_ram: simple dual-port RAM, one write port and one registered read port
module block_store_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2048,
  parameter int INIT  = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] r_rdata;
  if (INIT != 0) begin : g_init
    logic [WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    // write port; the array is zeroed at elaboration only, reset never touches it
    always_ff @(posedge clock) if (i_we) r_mem[i_waddr] <= i_wdata;
    assign w_q = r_mem[i_raddr];
  end else begin : g_raw
    logic [WIDTH-1:0] r_mem [DEPTH];
    // write port
    always_ff @(posedge clock) if (i_we) r_mem[i_waddr] <= i_wdata;
    assign w_q = r_mem[i_raddr];
  end
  // registered read: old data on a same-address write, held when no read is requested
  always_ff @(posedge clock) begin
    if (!reset) r_rdata <= '0;
    else if (i_re) r_rdata <= w_q;
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/decrypted_block_store.sv
// decrypted_block_store: captures decrypted blocks, tracks image completion, serves reads
module decrypted_block_store
  import decrypted_block_store_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2048,
  parameter int INIT  = 0,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dec_data,
  input  logic             dec_valid,
  input  logic [AW-1:0]    dec_addr,
  input  logic             arm,
  input  logic [AW:0]      num_blocks,
  output logic             filling,
  output logic             full,
  output logic [AW:0]      blk_count,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_miss,
  output logic             err_dup,
  output logic             err_range
);
  store_state_e r_state, w_next;
  logic [AW:0] r_num, r_count;
  logic [DEPTH-1:0] r_valid;
  logic r_err_dup, r_err_range, r_rd_valid, r_rd_miss;
  logic w_fill, w_full, w_in_range, w_was_set, w_store, w_err_range;
  assign w_fill      = r_state == ST_FILL;
  assign w_full      = r_state == ST_FULL;
  assign w_in_range  = {1'b0, dec_addr} < r_num;
  assign w_was_set   = r_valid[dec_addr];
  assign w_store     = dec_valid && !arm && w_fill && w_in_range;
  assign w_err_range = dec_valid && !arm && (w_full || (w_fill && !w_in_range));
  // next state: arm always wins; the completing write moves to FULL on its own edge
  always_comb begin
    w_next = r_state;
    if (arm) w_next = (num_blocks == '0) ? ST_FULL : ST_FILL;
    else if (w_store && !w_was_set && (r_count + 1'b1) == r_num) w_next = ST_FULL;
  end
  // state register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // image bookkeeping: valid map, distinct-block count and sticky error flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_num       <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_err_dup   <= 1'b0;
      r_err_range <= 1'b0;
    end else if (arm) begin
      r_num       <= num_blocks;
      r_count     <= '0;
      r_valid     <= '0;
      r_err_dup   <= 1'b0;
      r_err_range <= 1'b0;
    end else begin
      if (w_store) r_valid[dec_addr] <= 1'b1;
      if (w_store && !w_was_set) r_count <= r_count + 1'b1;
      if (w_store && w_was_set) r_err_dup <= 1'b1;
      if (w_err_range) r_err_range <= 1'b1;
    end
  end
  // read status: miss reflects the valid bit before any same-cycle write
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_miss  <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_miss <= ~r_valid[rd_addr];
    end
  end
  block_store_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_store && reset),
    .i_waddr (dec_addr),
    .i_wdata (dec_data),
    .i_re    (rd_req),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );
  assign filling   = w_fill;
  assign full      = w_full;
  assign blk_count = r_count;
  assign rd_valid  = r_rd_valid;
  assign rd_miss   = r_rd_miss;
  assign err_dup   = r_err_dup;
  assign err_range = r_err_range;
endmodule

// File: tb/tb_decrypted_block_store.sv
// tb_decrypted_block_store: directed table plus randomized run against a behavioural model
module tb_decrypted_block_store;
  localparam int W = 128;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst_n, arm, dv, rq, fil, ful, rv, miss, dup, rng;
  logic [4:0] nb, cnt;
  logic [3:0] da, ra;
  logic [W-1:0] dd, rd;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  decrypted_block_store #(.WIDTH(W), .DEPTH(D), .INIT(0)) dut (
    .clock(clk), .reset(rst_n), .dec_data(dd), .dec_valid(dv), .dec_addr(da),
    .arm(arm), .num_blocks(nb), .filling(fil), .full(ful), .blk_count(cnt),
    .rd_req(rq), .rd_addr(ra), .rd_data(rd), .rd_valid(rv), .rd_miss(miss),
    .err_dup(dup), .err_range(rng)
  );
  // behavioural model: image is complete when the distinct-entry count reaches num_blocks
  logic [W-1:0] m_mem [D];
  bit m_known [D];
  bit m_valid [D];
  int m_num = 0, m_cnt = 0;
  bit m_armed = 0, m_dup = 0, m_rng = 0, m_rv = 0, m_rm = 0, m_rd_known = 0;
  logic [W-1:0] m_rd = '0;
  task automatic model_edge();
    if (!rst_n) begin
      m_armed = 0; m_cnt = 0; m_dup = 0; m_rng = 0; m_rv = 0; m_rm = 0;
      m_rd = '0; m_rd_known = 1;
      foreach (m_valid[i]) m_valid[i] = 0;
    end else begin
      m_rv = rq;
      if (rq) begin
        m_rd = m_mem[ra]; m_rd_known = m_known[ra]; m_rm = !m_valid[ra];
      end
      if (arm) begin
        m_num = int'(nb); m_cnt = 0; m_dup = 0; m_rng = 0; m_armed = 1;
        foreach (m_valid[i]) m_valid[i] = 0;
      end else if (dv && m_armed) begin
        if (m_cnt == m_num || int'(da) >= m_num) m_rng = 1;
        else begin
          if (m_valid[da]) m_dup = 1;
          else m_cnt++;
          m_valid[da] = 1; m_mem[da] = dd; m_known[da] = 1;
        end
      end
    end
  endtask
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string n, logic [W-1:0] a, logic [W-1:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else pass++;
  endtask
  task automatic check_model(string t);
    chk({t, "_filling"}, W'(fil), W'(m_armed && m_cnt != m_num));
    chk({t, "_full"}, W'(ful), W'(m_armed && m_cnt == m_num));
    chk({t, "_count"}, W'(cnt), W'(m_cnt));
    chk({t, "_rd_valid"}, W'(rv), W'(m_rv));
    chk({t, "_rd_miss"}, W'(miss), W'(m_rm));
    chk({t, "_err_dup"}, W'(dup), W'(m_dup));
    chk({t, "_err_range"}, W'(rng), W'(m_rng));
    if (m_rd_known) chk({t, "_rd_data"}, rd, m_rd);
  endtask
  typedef struct {
    logic rst_n, arm; logic [4:0] nb; logic dv; logic [3:0] da; logic [W-1:0] dd;
    logic rq; logic [3:0] ra;
    logic fil, ful; logic [4:0] cnt; logic rv, miss, dup, rng, crd; logic [W-1:0] rd;
  } vec_t;
  vec_t tbl[$];
  task automatic row(int r, int a, int n, int v, int ad, logic [W-1:0] d, int q, int qa,
                     int f, int u, int c, int x, int m, int p, int g, int k, logic [W-1:0] e);
    vec_t t;
    t.rst_n = 1'(r); t.arm = 1'(a); t.nb = 5'(n); t.dv = 1'(v); t.da = 4'(ad); t.dd = d;
    t.rq = 1'(q); t.ra = 4'(qa); t.fil = 1'(f); t.ful = 1'(u); t.cnt = 5'(c);
    t.rv = 1'(x); t.miss = 1'(m); t.dup = 1'(p); t.rng = 1'(g); t.crd = 1'(k); t.rd = e;
    tbl.push_back(t);
  endtask
  initial begin
    logic [W-1:0] aa, bb, ff;
    aa = {16{8'hAA}}; bb = {16{8'hBB}}; ff = {16{8'hFF}};
    rst_n = 0; arm = 0; nb = '0; dv = 0; da = '0; dd = '0; rq = 0; ra = '0;
    repeat (20) cyc();
    chk("reset_filling", W'(fil), '0);
    chk("reset_full", W'(ful), '0);
    chk("reset_count", W'(cnt), '0);
    chk("reset_rd_valid", W'(rv), '0);
    chk("reset_errs", W'({dup, rng}), '0);
    chk("reset_rd_data", rd, '0);
    rst_n = 1; rq = 1; ra = 4'd5;
    cyc();
    rq = 0;
    chk("idle_rd_valid", W'(rv), W'(1));
    chk("idle_rd_miss", W'(miss), W'(1));
    chk("idle_count", W'(cnt), '0);
    //  rst arm nb dv ad data      rq ra  fil ful cnt rv miss dup rng crd rd
    row(1, 1, 3, 0, 0, '0,        0, 0,  1, 0, 0, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 0, 128'h01,   0, 0,  1, 0, 1, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 1, 128'h02,   0, 0,  1, 0, 2, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 2, 128'h03,   0, 0,  0, 1, 3, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 0, 0, '0,        1, 0,  0, 1, 3, 1, 0, 0, 0, 1, 128'h01);
    row(1, 0, 0, 0, 0, '0,        1, 1,  0, 1, 3, 1, 0, 0, 0, 1, 128'h02);
    row(1, 0, 0, 0, 0, '0,        1, 2,  0, 1, 3, 1, 0, 0, 0, 1, 128'h03);
    row(1, 1, 4, 0, 0, '0,        0, 0,  1, 0, 0, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 2, aa,        0, 0,  1, 0, 1, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 2, bb,        0, 0,  1, 0, 1, 0, 0, 1, 0, 0, '0);
    row(1, 0, 0, 0, 0, '0,        1, 2,  1, 0, 1, 1, 0, 1, 0, 1, bb);
    row(1, 1, 2, 0, 0, '0,        0, 0,  1, 0, 0, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 7, 128'h77,   0, 0,  1, 0, 0, 0, 0, 0, 1, 0, '0);
    row(1, 0, 0, 1, 0, 128'h10,   0, 0,  1, 0, 1, 0, 0, 0, 1, 0, '0);
    row(1, 0, 0, 1, 1, 128'h11,   0, 0,  0, 1, 2, 0, 0, 0, 1, 0, '0);
    row(1, 0, 0, 1, 0, 128'h99,   0, 0,  0, 1, 2, 0, 0, 0, 1, 0, '0);
    row(1, 0, 0, 0, 0, '0,        1, 0,  0, 1, 2, 1, 0, 0, 1, 1, 128'h10);
    row(1, 1, 4, 0, 0, '0,        0, 0,  1, 0, 0, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 3, ff,        1, 3,  1, 0, 1, 1, 1, 0, 0, 0, '0);
    row(1, 0, 0, 0, 0, '0,        1, 3,  1, 0, 1, 1, 0, 0, 0, 1, ff);
    row(1, 1, 0, 0, 0, '0,        0, 0,  0, 1, 0, 0, 0, 0, 0, 0, '0);
    row(1, 1, 4, 1, 1, 128'h55,   0, 0,  1, 0, 0, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 0, 0, '0,        1, 1,  1, 0, 0, 1, 1, 0, 0, 1, 128'h11);
    row(1, 0, 0, 1, 0, 128'h07,   0, 0,  1, 0, 1, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 1, 1, 128'h08,   0, 0,  1, 0, 2, 0, 0, 0, 0, 0, '0);
    row(0, 0, 0, 1, 2, 128'hEE,   0, 0,  0, 0, 0, 0, 0, 0, 0, 0, '0);
    row(1, 0, 0, 0, 0, '0,        1, 0,  0, 0, 0, 1, 1, 0, 0, 1, 128'h07);
    row(1, 0, 0, 0, 0, '0,        1, 2,  0, 0, 0, 1, 1, 0, 0, 1, bb);
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; arm = tbl[i].arm; nb = tbl[i].nb; dv = tbl[i].dv;
      da = tbl[i].da; dd = tbl[i].dd; rq = tbl[i].rq; ra = tbl[i].ra;
      cyc();
      chk($sformatf("row%0d_filling", i), W'(fil), W'(tbl[i].fil));
      chk($sformatf("row%0d_full", i), W'(ful), W'(tbl[i].ful));
      chk($sformatf("row%0d_count", i), W'(cnt), W'(tbl[i].cnt));
      chk($sformatf("row%0d_rd_valid", i), W'(rv), W'(tbl[i].rv));
      chk($sformatf("row%0d_err_dup", i), W'(dup), W'(tbl[i].dup));
      chk($sformatf("row%0d_err_range", i), W'(rng), W'(tbl[i].rng));
      if (tbl[i].rv) chk($sformatf("row%0d_rd_miss", i), W'(miss), W'(tbl[i].miss));
      if (tbl[i].rv && tbl[i].crd) chk($sformatf("row%0d_rd_data", i), rd, tbl[i].rd);
    end
    rst_n = 1; arm = 1; nb = 5'd16; dv = 0; rq = 0;
    cyc();
    arm = 0; dv = 1;
    for (int i = 0; i < D; i++) begin
      da = 4'(15 - i); dd = W'(i * 3 + 1);
      cyc();
      check_model($sformatf("depth%0d", i));
    end
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom % 150) != 0;
      arm = ($urandom % 14) == 0;
      nb = ($urandom % 3 == 0) ? 5'($urandom_range(0, 16)) : 5'($urandom_range(1, 4));
      dv = ($urandom % 4) != 0;
      da = ($urandom % 2 == 0) ? 4'($urandom_range(0, 4)) : 4'($urandom);
      dd = {$urandom, $urandom, $urandom, $urandom};
      rq = $urandom % 2;
      ra = 4'($urandom);
      cyc();
      check_model($sformatf("rnd%0d", i));
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
